// File: rtl/fetch_pkg.sv
// Shared constants and entry type for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned ILEN_DEFAULT = 32;
    localparam int unsigned PC_STEP      = 4;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [ILEN_DEFAULT-1:0] instr;
        logic                    fault;
        logic                    filled;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Reservation-based prefetch queue: entries are reserved at request time
// and filled in order as responses return; the head pops once filled.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEFAULT,
    parameter int unsigned ILEN   = ILEN_DEFAULT,
    parameter int unsigned QDEPTH = 4,
    localparam int unsigned PTR_W = $clog2(QDEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [XLEN-1:0]  push_pc,
    input  logic             fill,
    input  logic [ILEN-1:0]  fill_instr,
    input  logic             fill_fault,
    input  logic             pop,
    output logic             full,
    output logic [CNT_W-1:0] unfilled,
    output logic             head_valid,
    output logic [XLEN-1:0]  head_pc,
    output logic [ILEN-1:0]  head_instr,
    output logic             head_fault
);

    logic [XLEN-1:0]   pc_mem    [QDEPTH];
    logic [ILEN-1:0]   instr_mem [QDEPTH];
    logic [QDEPTH-1:0] fault_mem;

    logic [PTR_W-1:0] head_q, tail_q, fill_q;
    logic [CNT_W-1:0] count_q, unfilled_q;
    logic             do_push, do_fill, do_pop;

    assign full       = (count_q == CNT_W'(QDEPTH));
    assign unfilled   = unfilled_q;
    // Fills land in order, so the head is filled whenever any entry is.
    assign head_valid = (count_q != unfilled_q);
    assign head_pc    = pc_mem[head_q];
    assign head_instr = instr_mem[head_q];
    assign head_fault = fault_mem[head_q];

    assign do_push = push && !flush && !full;
    assign do_fill = fill && !flush && (unfilled_q != '0);
    assign do_pop  = pop  && !flush && head_valid;

    // Pointers and occupancy counts; flush empties the queue in one cycle.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            fill_q     <= '0;
            count_q    <= '0;
            unfilled_q <= '0;
        end else if (flush) begin
            head_q     <= '0;
            tail_q     <= '0;
            fill_q     <= '0;
            count_q    <= '0;
            unfilled_q <= '0;
        end else begin
            if (do_push) tail_q <= tail_q + PTR_W'(1);
            if (do_fill) fill_q <= fill_q + PTR_W'(1);
            if (do_pop)  head_q <= head_q + PTR_W'(1);
            count_q    <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
            unfilled_q <= unfilled_q + CNT_W'(do_push) - CNT_W'(do_fill);
        end
    end

    // Payload storage; validity is tracked purely by the counters above.
    always_ff @(posedge clk) begin
        if (do_push) pc_mem[tail_q] <= push_pc;
        if (do_fill) begin
            instr_mem[fill_q] <= fill_instr;
            fault_mem[fill_q] <= fill_fault;
        end
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch stage: sequential request issue, stale-response dropping
// after redirects, and a prefetch queue feeding decode.
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEFAULT,
    parameter int unsigned     ILEN     = ILEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     QDEPTH   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            imem_rsp_err,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_pc,
    output logic [XLEN-1:0] dec_npc,
    output logic [ILEN-1:0] dec_instr,
    output logic            dec_fault
);

    localparam int unsigned     CNT_W       = $clog2(QDEPTH) + 1;
    // Headroom for stale responses left behind by back-to-back redirects.
    localparam int unsigned     DROP_W      = CNT_W + 3;
    localparam logic [XLEN-1:0] RESET_PC_AL = RESET_PC & ~XLEN'(3);

    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [DROP_W-1:0] drop_q, drop_d, in_flight;
    logic              q_full, q_head_valid, q_head_fault;
    logic [CNT_W-1:0]  q_unfilled;
    logic [XLEN-1:0]   q_head_pc;
    logic [ILEN-1:0]   q_head_instr;
    logic              req_fire, rsp_fill;

    assign imem_req_valid = !rst_n && !redirect_valid && !q_full;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_fill       = imem_rsp_valid && !redirect_valid && (drop_q == '0);
    assign in_flight      = drop_q + DROP_W'(q_unfilled);

    assign dec_valid = q_head_valid;
    assign dec_pc    = q_head_valid ? q_head_pc : '0;
    assign dec_npc   = q_head_valid ? q_head_pc + XLEN'(PC_STEP) : '0;
    assign dec_instr = q_head_valid ? q_head_instr : '0;
    assign dec_fault = q_head_valid && q_head_fault;

    // Next fetch PC and count of responses still owed to flushed requests.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~XLEN'(3);
            drop_d     = in_flight - DROP_W'(imem_rsp_valid && (in_flight != '0));
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
            if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - DROP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            fetch_pc_q <= RESET_PC_AL;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_q     <= drop_d;
        end
    end

    fetch_queue #(
        .XLEN   (XLEN),
        .ILEN   (ILEN),
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push       (req_fire),
        .push_pc    (fetch_pc_q),
        .fill       (rsp_fill),
        .fill_instr (imem_rsp_data),
        .fill_fault (imem_rsp_err),
        .pop        (dec_ready),
        .full       (q_full),
        .unfilled   (q_unfilled),
        .head_valid (q_head_valid),
        .head_pc    (q_head_pc),
        .head_instr (q_head_instr),
        .head_fault (q_head_fault)
    );

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: directed vector table, corner sequences and a
// randomized run checked against an epoch-tagged queue/memory model.
module tb_fetch_prefetch_unit;
    import fetch_pkg::*;

    localparam int unsigned QD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        imem_rsp_err = 1'b0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_pc, dec_npc, dec_instr;
    logic        dec_fault;

    fetch_prefetch_unit #(
        .XLEN(32), .ILEN(32), .RESET_PC(32'h0), .QDEPTH(QD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .imem_rsp_err(imem_rsp_err),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_pc(dec_pc), .dec_npc(dec_npc), .dec_instr(dec_instr), .dec_fault(dec_fault)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic err; int ep; int due; } mreq_t;
    typedef struct {
        logic redir; logic [31:0] rpc;
        logic exp_rv; logic [31:0] exp_ra; logic exp_dv; logic [31:0] exp_dpc;
    } vec_t;

    fq_entry_t   mq[$];     // model of entries visible to decode, oldest first
    mreq_t       memq[$];   // requests in flight in the memory
    logic [31:0] m_pc;
    int          epoch, cyc, last_due, lat_min, lat_max;
    bit          err_at8, rand_err;
    int          n_tests, n_fail;

    logic [31:0] c_pc[4], c_npc[4], c_ins[4];
    logic        c_flt[4];
    int          got;
    logic [31:0] first_ra;
    bit          ra_seen;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_rsp_err   = 1'b0;
        dec_ready      = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst_req_addr",  imem_req_addr, 32'h0);
        chk("rst_dec_valid", 32'(dec_valid), 32'h0);
        chk("rst_dec_pc",    dec_pc, 32'h0);
        chk("rst_dec_npc",   dec_npc, 32'h0);
        chk("rst_dec_instr", dec_instr, 32'h0);
        chk("rst_dec_fault", 32'(dec_fault), 32'h0);
        mq.delete();
        memq.delete();
        m_pc = '0; epoch = 0; cyc = 0; last_due = -1;
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    // Apply one cycle of inputs, compare DUT against the model, then advance the model.
    task automatic drive(input logic redir, input logic [31:0] rpc,
                         input logic rq_rdy, input logic d_rdy);
        bit        rsp, head_ok, exp_rv, found;
        mreq_t     r, nr;
        fq_entry_t e;
        int        d;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = rq_rdy;
        dec_ready      = d_rdy;
        rsp = (memq.size() > 0) && (memq[0].due <= cyc);
        if (rsp) r = memq[0];
        else     r = '{addr: '0, err: 1'b0, ep: 0, due: 0};
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? instr_of(r.addr) : '0;
        imem_rsp_err   = rsp && r.err;
        #1;
        exp_rv  = !redir && (mq.size() < QD);
        head_ok = (mq.size() > 0) && mq[0].filled;
        chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        chk("req_addr",  imem_req_addr, m_pc);
        chk("dec_valid", 32'(dec_valid), 32'(head_ok));
        chk("dec_pc",    dec_pc,    head_ok ? mq[0].pc : 32'h0);
        chk("dec_npc",   dec_npc,   head_ok ? mq[0].pc + 32'd4 : 32'h0);
        chk("dec_instr", dec_instr, head_ok ? mq[0].instr : 32'h0);
        chk("dec_fault", 32'(dec_fault), head_ok ? 32'(mq[0].fault) : 32'h0);

        if (rsp) begin
            void'(memq.pop_front());
            if (!redir && r.ep == epoch) begin
                found = 1'b0;
                for (int i = 0; i < mq.size(); i++) begin
                    if (!found && !mq[i].filled) begin
                        e = mq[i];
                        e.instr = instr_of(r.addr);
                        e.fault = r.err;
                        e.filled = 1'b1;
                        mq[i] = e;
                        found = 1'b1;
                    end
                end
            end
        end
        if (head_ok && d_rdy) void'(mq.pop_front());
        if (redir) begin
            mq.delete();
            epoch++;
            m_pc = rpc & ~32'h3;
        end else if (exp_rv && rq_rdy) begin
            e = '{pc: m_pc, instr: 32'h0, fault: 1'b0, filled: 1'b0};
            mq.push_back(e);
            d = cyc + int'($urandom_range(lat_max, lat_min));
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            nr.addr = m_pc;
            nr.err  = err_at8 ? (m_pc == 32'h8) : (rand_err && ($urandom_range(7) == 0));
            nr.ep   = epoch;
            nr.due  = d;
            memq.push_back(nr);
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    // Run with ready memory and decode until n instructions are delivered.
    task automatic collect(input int n, input int bound);
        got = 0;
        ra_seen = 1'b0;
        first_ra = 32'hDEAD_BEEF;
        for (int k = 0; k < bound && got < n; k++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b1);
            if (!ra_seen && imem_req_valid) begin
                ra_seen = 1'b1;
                first_ra = imem_req_addr;
            end
            if (dec_valid && dec_ready && got < 4) begin
                c_pc[got] = dec_pc; c_npc[got] = dec_npc;
                c_ins[got] = dec_instr; c_flt[got] = dec_fault;
                got++;
            end
            tick();
        end
        chk("collect_count", 32'(got), 32'(n));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tab[10];
        int   acc;
        n_tests = 0; n_fail = 0;
        err_at8 = 1'b0; rand_err = 1'b0; lat_min = 1; lat_max = 1;

        // redir, rpc, exp req_valid, exp req_addr, exp dec_valid, exp dec_pc
        tab[0] = '{1'b0, 32'h0,   1'b1, 32'h000, 1'b0, 32'h000};
        tab[1] = '{1'b0, 32'h0,   1'b1, 32'h004, 1'b0, 32'h000};
        tab[2] = '{1'b0, 32'h0,   1'b1, 32'h008, 1'b1, 32'h000};
        tab[3] = '{1'b0, 32'h0,   1'b1, 32'h00C, 1'b1, 32'h004};
        tab[4] = '{1'b0, 32'h0,   1'b1, 32'h010, 1'b1, 32'h008};
        tab[5] = '{1'b1, 32'h200, 1'b0, 32'h014, 1'b1, 32'h00C};
        tab[6] = '{1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h000};
        tab[7] = '{1'b0, 32'h0,   1'b1, 32'h204, 1'b0, 32'h000};
        tab[8] = '{1'b0, 32'h0,   1'b1, 32'h208, 1'b1, 32'h200};
        tab[9] = '{1'b0, 32'h0,   1'b1, 32'h20C, 1'b1, 32'h204};

        #2;
        do_reset();

        // Streaming with 1-cycle memory, redirect hitting a response and a handshake.
        for (int i = 0; i < 10; i++) begin
            drive(tab[i].redir, tab[i].rpc, 1'b1, 1'b1);
            chk("tab_req_valid", 32'(imem_req_valid), 32'(tab[i].exp_rv));
            chk("tab_req_addr",  imem_req_addr, tab[i].exp_ra);
            chk("tab_dec_valid", 32'(dec_valid), 32'(tab[i].exp_dv));
            chk("tab_dec_pc",    dec_pc, tab[i].exp_dpc);
            tick();
        end

        // Decode stalled: queue fills to 4, then drains in order with a fault at 0x8.
        do_reset();
        err_at8 = 1'b1;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            if (imem_req_valid && imem_req_ready) acc++;
            tick();
        end
        chk("stall_accepts", 32'(acc), 32'd4);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("full_req_valid", 32'(imem_req_valid), 32'h0);
        tick();
        collect(4, 20);
        chk("drain_pc0", c_pc[0], 32'h0);
        chk("drain_pc1", c_pc[1], 32'h4);
        chk("drain_pc2", c_pc[2], 32'h8);
        chk("drain_pc3", c_pc[3], 32'hC);
        chk("fault_pc0", 32'(c_flt[0]), 32'h0);
        chk("fault_pc4", 32'(c_flt[1]), 32'h0);
        chk("fault_pc8", 32'(c_flt[2]), 32'h1);
        chk("fault_pcC", 32'(c_flt[3]), 32'h0);
        chk("resume_addr", first_ra, 32'h10);
        err_at8 = 1'b0;

        // Latency 3, two requests outstanding, redirect before either returns.
        do_reset();
        lat_min = 3; lat_max = 3;
        drive(1'b0, 32'h0, 1'b1, 1'b1); tick();
        drive(1'b0, 32'h0, 1'b1, 1'b1); tick();
        drive(1'b1, 32'h200, 1'b1, 1'b1); tick();
        collect(2, 30);
        chk("lat3_pc0",    c_pc[0], 32'h200);
        chk("lat3_instr0", c_ins[0], instr_of(32'h200));
        chk("lat3_pc1",    c_pc[1], 32'h204);
        chk("lat3_instr1", c_ins[1], instr_of(32'h204));

        // Redirect to the top of the address space and wrap.
        lat_min = 1; lat_max = 1;
        drive(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1); tick();
        collect(2, 20);
        chk("wrap_pc0",  c_pc[0],  32'hFFFF_FFFC);
        chk("wrap_npc0", c_npc[0], 32'h0);
        chk("wrap_pc1",  c_pc[1],  32'h0);

        // Randomized traffic with a reset in the middle.
        rand_err = 1'b1; lat_min = 1; lat_max = 4;
        for (int k = 0; k < 3000; k++) begin
            if (k == 1500) do_reset();
            drive($urandom_range(19) == 0, $urandom(),
                  $urandom_range(3) != 0, $urandom_range(3) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch_unit.md
# fetch_prefetch_unit

Parametrised instruction-fetch stage with a reservation-based prefetch queue between instruction memory and decode. It issues sequential fetch requests over a valid/ready memory port, tolerates variable in-order response latency, and buffers up to QDEPTH instructions. It presents them to decode over a valid/ready handshake and supports single-cycle redirect/flush from branch resolution. Sits between the instruction-memory port and the decode stage.

## Interface
- XLEN, 32: PC/address width.
- ILEN, 32: instruction width.
- RESET_PC, 0: PC after reset; low two bits forced to 0.
- QDEPTH, 4: queue entries; power of two, ≥2. Also bounds outstanding requests.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-high.
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  XLEN  new fetch PC; bits [1:0] ignored, treated as 0.
- imem_req_valid  out  1  fetch request.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  response; in request order, at most one per cycle.
- imem_rsp_data  in  ILEN  fetched instruction.
- imem_rsp_err  in  1  access fault for this response.
- dec_valid  out  1  head entry filled and presentable.
- dec_ready  in  1  decode accepts.
- dec_pc  out  XLEN  PC of presented instruction.
- dec_npc  out  XLEN  dec_pc + 4, modulo 2^XLEN.
- dec_instr  out  ILEN  instruction; 0 when dec_valid=0.
- dec_fault  out  1  access fault flag of presented entry.

## Operation
- fetch_pc register: reset RESET_PC. +4 on each accepted request (wraps modulo 2^XLEN). Loaded with redirect_pc on redirect.
- Request issue: imem_req_valid = !redirect_valid && (reserved entries < QDEPTH). imem_req_addr = fetch_pc.
- Once raised, imem_req_valid and imem_req_addr stay stable until accepted. The only exception is withdrawal in a redirect cycle.
- Acceptance (valid && ready) reserves the tail entry {pc, filled=0}.
- Response, with drop_cnt=0: fills the oldest unfilled entry with {instr, fault, filled=1}.
- Response, with drop_cnt>0: discarded, drop_cnt decrements.
- Response with no unfilled entry and drop_cnt=0: ignored.
- Decode: dec_valid = head entry filled. A dec_valid && dec_ready handshake frees the head.
- dec_fault=1 entries are delivered normally. Fetch continues sequentially; decode/trap logic decides.
- Redirect: all entries invalidated. drop_cnt loads the number of reserved-but-unfilled entries. fetch_pc loads redirect_pc.
- Simultaneous events in a redirect cycle:
  - A decode handshake still completes; that instruction was consumed.
  - A response in the same cycle is discarded, and drop_cnt loads unfilled − 1.
  - A redirect while drop_cnt>0 adds the new unfilled count to the remaining drop_cnt.
- Full: reserved entries == QDEPTH, so imem_req_valid=0. Reservation and free in the same cycle keep occupancy constant.
- Reset (any time, including mid-flight): queue empty, drop_cnt=0, fetch_pc=RESET_PC, all outputs 0. Memory shares rst_n, so no pre-reset responses arrive afterwards.

## Timing
- Reset values: imem_req_valid=0, imem_req_addr=RESET_PC, dec_valid=0, dec_pc=0, dec_npc=0, dec_instr=0, dec_fault=0.
- First request: imem_req_valid=1 in the first clk cycle after rst_n deasserts.
- Request accepted cycle N, response cycle M≥N+1 → dec_valid at M+1 (registered queue).
- Steady state with 1-cycle memory and dec_ready=1: one instruction per cycle.
- Redirect in cycle R:
  - dec_valid=0 in R+1.
  - imem_req_valid=1 with addr=redirect_pc in R+1 (queue non-full by construction).
  - Earliest new dec_valid in R+3 with 1-cycle memory.
- Queue pointers wrap modulo QDEPTH.

## Structure
- fetch_pkg: XLEN/ILEN defaults, fq_entry_t struct {pc, instr, fault, filled}, PC_STEP=4 constant.
- One sub-module, fetch_queue. It holds the circular buffer with head, tail and fill pointers, occupancy/unfilled counts, and a flush input.
- Top level holds fetch_pc, drop_cnt and the handshake logic.

## Test plan
- Reset then stream with 1-cycle memory and dec_ready=1 → dec_pc 0x0,0x4,0x8… back-to-back; dec_npc = dec_pc+4.
- dec_ready=0 with QDEPTH=4 → exactly 4 requests accepted, then imem_req_valid=0; release → 4 instructions drain in order, fetch resumes at 0x10.
- Memory latency 3 with 2 requests outstanding, redirect to 0x200 → both stale responses dropped; next dec_pc=0x200, then 0x204.
- Redirect coincident with a response and a decode handshake → the handshaked instruction counts as delivered, the response is dropped, drop_cnt is correct, and there are no stale PCs after.
- imem_rsp_err=1 on address 0x8 → dec_fault=1 with dec_pc=0x8; neighbouring entries have fault=0.
- Redirect to 0xFFFFFFFC → dec_pc 0xFFFFFFFC then 0x00000000; dec_npc of the first is 0x0.
